mouse_click_ctl: RTL

MOUSE_CLICK_CTL -- requirements
Module: mouse_click_ctl

---
 rtl/mouse_pkg.sv | 33 +++
 rtl/debounce.sv | 46 ++++
 rtl/mouse_click_ctl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared types, screen limits and small helpers for the mouse click controller.
// No ports: imported by mouse_click_ctl and debounce.
package mouse_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned DIFF_W  = COORD_W + 1;

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(1023);
    localparam logic [COORD_W-1:0] V_MAX = COORD_W'(767);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        WAIT2    = 3'd2,
        PRESSED2 = 3'd3,
        DRAG     = 3'd4
    } state_t;

    // Saturate a coordinate to the visible screen limit.
    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // |a - b| using a signed difference one bit wider than the coordinates.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        logic signed [DIFF_W-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
    endfunction

endpackage

// File: rtl/debounce.sv
// Button debouncer: dout follows a level change on din only after din has
// disagreed with dout for DEBOUNCE_CYC consecutive cycles.
// Ports: clk, rst (async, active high), din (raw level), dout (debounced level).
module debounce
    import mouse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             btn_d, btn_q;

    // Count disagreeing cycles; toggle on the last one and restart from zero.
    always_comb begin
        cnt_d = '0;
        btn_d = btn_q;
        if (din != btn_q) begin
            if (cnt_q == CNT_LAST) begin
                btn_d = din;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            btn_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            btn_q <= btn_d;
        end
    end

    assign dout = btn_q;

endmodule

// File: rtl/mouse_click_ctl.sv
// Mouse click controller: debounces the left button, clamps the pointer to the
// screen and classifies presses into click, double click and drag events.
// Ports:
//   clk65MHz, rst        - clock and asynchronous active-high reset
//   left_in              - registered left-button level
//   xpos, ypos           - registered pointer position
//   cur_x, cur_y         - clamped current position
//   press_x, press_y     - clamped position at the last accepted press
//   btn                  - debounced button level
//   click, dclick        - one-cycle click / double-click pulses
//   drag_done            - one-cycle pulse when a drag is released
//   drag_active          - high while a drag is in progress
module mouse_click_ctl
    import mouse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 65000,
    parameter int unsigned DCLICK_CYC   = 19500000,
    parameter int unsigned DRAG_THRESH  = 4
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        left_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] cur_x,
    output logic [11:0] cur_y,
    output logic [11:0] press_x,
    output logic [11:0] press_y,
    output logic        btn,
    output logic        click,
    output logic        dclick,
    output logic        drag_done,
    output logic        drag_active
);

    localparam int unsigned       WIN_W    = (DCLICK_CYC > 0) ? $clog2(DCLICK_CYC + 1) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(DCLICK_CYC);
    localparam logic [DIFF_W-1:0] THRESH   = DIFF_W'(DRAG_THRESH);

    logic btn_db;

    debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk65MHz),
        .rst  (rst),
        .din  (left_in),
        .dout (btn_db)
    );

    state_t               state_d, state_q;
    logic [WIN_W-1:0]     win_d, win_q;
    logic [COORD_W-1:0]   cur_x_d, cur_x_q, cur_y_d, cur_y_q;
    logic [COORD_W-1:0]   press_x_d, press_x_q, press_y_d, press_y_q;
    logic                 btn_prev_d, btn_prev_q;
    logic                 click_d, click_q, dclick_d, dclick_q;
    logic                 drag_done_d, drag_done_q, drag_active_d, drag_active_q;

    logic rise_c, fall_c, moved_c;

    // Edges of the debounced level; the FSM reacts one cycle after btn moves.
    assign rise_c  = btn_db & ~btn_prev_q;
    assign fall_c  = ~btn_db & btn_prev_q;
    assign moved_c = (abs_diff(cur_x_q, press_x_q) > THRESH) ||
                     (abs_diff(cur_y_q, press_y_q) > THRESH);

    // Next-state, clamp and event logic. A release always wins over the drag
    // threshold, so a move detected on the release cycle still yields a click.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cur_x_d     = clamp(xpos, H_MAX);
        cur_y_d     = clamp(ypos, V_MAX);
        press_x_d   = press_x_q;
        press_y_d   = press_y_q;
        btn_prev_d  = btn_db;
        click_d     = 1'b0;
        dclick_d    = 1'b0;
        drag_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    press_x_d = cur_x_q;
                    press_y_d = cur_y_q;
                    state_d   = PRESSED;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    click_d = 1'b1;
                    win_d   = '0;
                    state_d = WAIT2;
                end else if (moved_c) begin
                    state_d = DRAG;
                end
            end
            WAIT2: begin
                win_d = win_q + WIN_W'(1);
                if (win_q == WIN_LAST) begin
                    // A press landing exactly on timeout starts a fresh click.
                    state_d = IDLE;
                    if (rise_c) begin
                        press_x_d = cur_x_q;
                        press_y_d = cur_y_q;
                        state_d   = PRESSED;
                    end
                end else if (rise_c) begin
                    press_x_d = cur_x_q;
                    press_y_d = cur_y_q;
                    state_d   = PRESSED2;
                end
            end
            PRESSED2: begin
                if (fall_c) begin
                    click_d  = 1'b1;
                    dclick_d = 1'b1;
                    state_d  = IDLE;
                end else if (moved_c) begin
                    state_d = DRAG;
                end
            end
            DRAG: begin
                if (fall_c) begin
                    drag_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drag_active_d = (state_d == DRAG);
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            win_q         <= '0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            press_x_q     <= '0;
            press_y_q     <= '0;
            btn_prev_q    <= 1'b0;
            click_q       <= 1'b0;
            dclick_q      <= 1'b0;
            drag_done_q   <= 1'b0;
            drag_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            press_x_q     <= press_x_d;
            press_y_q     <= press_y_d;
            btn_prev_q    <= btn_prev_d;
            click_q       <= click_d;
            dclick_q      <= dclick_d;
            drag_done_q   <= drag_done_d;
            drag_active_q <= drag_active_d;
        end
    end

    assign cur_x       = cur_x_q;
    assign cur_y       = cur_y_q;
    assign press_x     = press_x_q;
    assign press_y     = press_y_q;
    assign btn         = btn_db;
    assign click       = click_q;
    assign dclick      = dclick_q;
    assign drag_done   = drag_done_q;
    assign drag_active = drag_active_q;

endmodule
